// File: rtl/regfile_arbiter.sv
// Round-robin arbiter that serializes two requesters onto one register-file port.
// One access in flight: writes take IDLE+ISSUE, reads take IDLE+ISSUE+RWAIT.
module regfile_arbiter #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic          gnt_a,
  output logic          rvalid_a,
  output logic [DW-1:0] rdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_b,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_b,
  output logic          rf_we,
  output logic          rf_re,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_wdata,
  input  logic [DW-1:0] rf_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RWAIT} state_t;

  state_t        state_q, state_d;
  logic          last_b_q, last_b_d;   // 1 = B granted last, so A wins a tie
  logic          own_b_q, own_b_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_a_q, rdata_a_d;
  logic [DW-1:0] rdata_b_q, rdata_b_d;
  logic          rvalid_a_q, rvalid_a_d;
  logic          rvalid_b_q, rvalid_b_d;
  logic          pick_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_b_q   <= 1'b1;
      own_b_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      own_b_q    <= own_b_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_b_d   = last_b_q;
    own_b_d    = own_b_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    rvalid_a_d = 1'b0;
    rvalid_b_d = 1'b0;
    pick_b     = req_b & (~req_a | ~last_b_q);
    case (state_q)
      S_IDLE: begin
        if (req_a | req_b) begin
          own_b_d  = pick_b;
          last_b_d = pick_b;
          we_d     = pick_b ? we_b    : we_a;
          addr_d   = pick_b ? addr_b  : addr_a;
          wdata_d  = pick_b ? wdata_b : wdata_a;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: state_d = we_q ? S_IDLE : S_RWAIT;
      S_RWAIT: begin
        // rf_rdata is valid now; register it so rvalid lines up with IDLE
        if (own_b_q) begin
          rdata_b_d  = rf_rdata;
          rvalid_b_d = 1'b1;
        end else begin
          rdata_a_d  = rf_rdata;
          rvalid_a_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_a    = (state_q == S_ISSUE) & ~own_b_q;
    gnt_b    = (state_q == S_ISSUE) &  own_b_q;
    rf_we    = (state_q == S_ISSUE) &  we_q;
    rf_re    = (state_q == S_ISSUE) & ~we_q;
    rf_addr  = (state_q == S_ISSUE) ? addr_q : '0;
    rf_wdata = rf_we ? wdata_q : '0;
    rvalid_a = rvalid_a_q;
    rvalid_b = rvalid_b_q;
    rdata_a  = rdata_a_q;
    rdata_b  = rdata_b_q;
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural register-file model.
module tb_regfile_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, we_a, req_b, we_b;
  logic [2:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;
  logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [7:0] rdata_a, rdata_b;
  logic       rf_we, rf_re;
  logic [2:0] rf_addr;
  logic [7:0] rf_wdata, rf_rdata;
  logic [7:0] mem [8];
  logic [7:0] exp_ra, exp_rb;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_arbiter #(.DW(8), .AW(3)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .rf_we(rf_we), .rf_re(rf_re), .rf_addr(rf_addr),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  // Register file: write on strobe, read data valid the cycle after rf_re
  always @(posedge clk) begin
    if (rf_we) mem[rf_addr] <= rf_wdata;
    if (rf_re) rf_rdata <= mem[rf_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, " gnt"}, {30'd0, gnt_a, gnt_b}, 32'd0);
    chk({tag, " strobes"}, {30'd0, rf_we, rf_re}, 32'd0);
    chk({tag, " rf_addr"}, {29'd0, rf_addr}, 32'd0);
    chk({tag, " rf_wdata"}, {24'd0, rf_wdata}, 32'd0);
  endtask

  task automatic do_write(input bit is_b, input logic [2:0] a, input logic [7:0] d);
    if (is_b) begin req_b = 1; we_b = 1; addr_b = a; wdata_b = d; end
    else      begin req_a = 1; we_a = 1; addr_a = a; wdata_a = d; end
    tick;
    chk("wr gnt", {30'd0, gnt_a, gnt_b}, is_b ? 32'd1 : 32'd2);
    chk("wr strobes", {30'd0, rf_we, rf_re}, 32'd2);
    chk("wr rf_addr", {29'd0, rf_addr}, {29'd0, a});
    chk("wr rf_wdata", {24'd0, rf_wdata}, {24'd0, d});
    if (is_b) req_b = 0; else req_a = 0;
    tick;
    chk_idle_outs("wr done");
  endtask

  task automatic do_read(input bit is_b, input logic [2:0] a, input logic [7:0] exp);
    if (is_b) begin req_b = 1; we_b = 0; addr_b = a; end
    else      begin req_a = 1; we_a = 0; addr_a = a; end
    tick;
    chk("rd gnt", {30'd0, gnt_a, gnt_b}, is_b ? 32'd1 : 32'd2);
    chk("rd strobes", {30'd0, rf_we, rf_re}, 32'd1);
    chk("rd rf_addr", {29'd0, rf_addr}, {29'd0, a});
    chk("rd rf_wdata", {24'd0, rf_wdata}, 32'd0);
    if (is_b) req_b = 0; else req_a = 0;
    tick;
    chk_idle_outs("rwait");
    chk("rwait rvalid", {30'd0, rvalid_a, rvalid_b}, 32'd0);
    tick;
    if (is_b) exp_rb = exp; else exp_ra = exp;
    chk("rd rvalid", {30'd0, rvalid_a, rvalid_b}, is_b ? 32'd1 : 32'd2);
    chk("rd rdata_a", {24'd0, rdata_a}, {24'd0, exp_ra});
    chk("rd rdata_b", {24'd0, rdata_b}, {24'd0, exp_rb});
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    rf_rdata = 8'h00;
    rst = 1; req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
    req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
    exp_ra = 8'h00; exp_rb = 8'h00;
    tick; tick;
    chk_idle_outs("reset");
    chk("reset rvalid", {30'd0, rvalid_a, rvalid_b}, 32'd0);
    chk("reset rdata", {16'd0, rdata_a, rdata_b}, 32'd0);

    // First edge with rst low samples the request
    rst = 0;
    do_write(0, 3'd3, 8'h5A);
    do_read(0, 3'd3, 8'h5A);
    tick;
    chk("rvalid pulse", {30'd0, rvalid_a, rvalid_b}, 32'd0);
    chk("rdata_a hold", {24'd0, rdata_a}, 32'h5A);

    // Contention after reset: A, B, A, B
    rst = 1; tick; rst = 0;
    exp_ra = 8'h00; exp_rb = 8'h00;
    req_a = 1; we_a = 1; addr_a = 3'd1; wdata_a = 8'h11;
    req_b = 1; we_b = 1; addr_b = 3'd2; wdata_b = 8'h22;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rr gnt", {30'd0, gnt_a, gnt_b}, (i % 2 == 0) ? 32'd2 : 32'd1);
      tick;
      chk("rr idle gnt", {30'd0, gnt_a, gnt_b}, 32'd0);
    end
    req_a = 0; req_b = 0;
    tick;
    chk("rr mem", {16'd0, mem[1], mem[2]}, 32'h1122);

    // B granted last: A read of 7 beats B write of 7, returns old value
    req_a = 1; we_a = 0; addr_a = 3'd7;
    req_b = 1; we_b = 1; addr_b = 3'd7; wdata_b = 8'hFF;
    tick;
    chk("ab gnt", {30'd0, gnt_a, gnt_b}, 32'd2);
    chk("ab rf_re", {30'd0, rf_we, rf_re}, 32'd1);
    req_a = 0;
    tick;
    tick;
    chk("ab rvalid", {30'd0, rvalid_a, rvalid_b}, 32'd2);
    chk("ab old data", {24'd0, rdata_a}, 32'h00);
    tick;
    chk("ab b gnt", {30'd0, gnt_a, gnt_b}, 32'd1);
    chk("ab b wdata", {21'd0, rf_addr, rf_wdata}, {21'd0, 3'd7, 8'hFF});
    req_b = 0;
    tick;
    exp_ra = 8'h00;

    // Boundaries on both requesters
    do_read(1, 3'd7, 8'hFF);
    do_write(0, 3'd0, 8'hFF);
    do_read(1, 3'd0, 8'hFF);
    do_write(1, 3'd0, 8'h00);
    do_read(0, 3'd0, 8'h00);

    // Reset in RWAIT aborts the read
    req_a = 1; we_a = 0; addr_a = 3'd7;
    tick;
    chk("abort gnt", {30'd0, gnt_a, gnt_b}, 32'd2);
    req_a = 0;
    tick;
    rst = 1;
    tick;
    chk_idle_outs("abort");
    chk("abort rvalid", {30'd0, rvalid_a, rvalid_b}, 32'd0);
    chk("abort rdata", {16'd0, rdata_a, rdata_b}, 32'd0);
    rst = 0;
    req_a = 1; we_a = 1; addr_a = 3'd5; wdata_a = 8'h33;
    req_b = 1; we_b = 1; addr_b = 3'd6; wdata_b = 8'h44;
    tick;
    chk("post rst gnt", {30'd0, gnt_a, gnt_b}, 32'd2);
    chk("post rst rvalid", {30'd0, rvalid_a, rvalid_b}, 32'd0);
    req_a = 0;
    tick;
    tick;
    chk("post rst b", {30'd0, gnt_a, gnt_b}, 32'd1);
    req_b = 0;
    tick;
    tick;
    chk("post rst mem", {16'd0, mem[5], mem[6]}, 32'h3344);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): DW, 8, data width; AW, 3, register-address width (8 registers).
REQ-002 SHALL have ports (name  direction  width  meaning), clock and reset first:
  clk  in  1  single clock; all logic on rising edge
  rst  in  1  synchronous, active-high reset
  req_a  in  1  requester A wants one register-file access
  we_a  in  1  A: 1 = write, 0 = read
  addr_a  in  AW  A register address
  wdata_a  in  DW  A write data
  gnt_a  out  1  A command accepted (one-cycle pulse)
  rvalid_a  out  1  A read data valid (one-cycle pulse)
  rdata_a  out  DW  A read data
  req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b  same as A, for requester B
  rf_we  out  1  register-file write strobe
  rf_re  out  1  register-file read strobe
  rf_addr  out  AW  register-file address
  rf_wdata  out  DW  register-file write data
  rf_rdata  in  DW  register-file read data, valid the cycle after rf_re

Function
REQ-003 SHALL serialize accesses from A and B onto the single register-file port; at most one access in flight.
REQ-004 SHALL implement FSM states IDLE, ISSUE, RWAIT.
REQ-005 IDLE: req_a, req_b sampled only here; if neither high, stay IDLE; else select a winner, capture its we/addr/wdata at this edge, go to ISSUE.
REQ-006 Arbitration SHALL be round-robin: one requester high -> it wins; both high -> winner is the one not granted last; last-grant pointer updates on each grant.
REQ-007 ISSUE: gnt_x of winner SHALL be 1 for exactly this cycle; rf_addr = captured address; write -> rf_we = 1, rf_wdata = captured data, next state IDLE; read -> rf_re = 1, next state RWAIT.
REQ-008 RWAIT: rf_rdata SHALL be registered into rdata_x of the read's owner; rvalid_x = 1 the following cycle (simultaneous with IDLE); next state IDLE.
REQ-009 Latency SHALL be: write gnt 1 cycle after request sampled; read data 3 cycles after request sampled; write occupies 2 cycles, read 3.
REQ-010 rf_we, rf_re SHALL be 0 outside ISSUE; never both 1; rf_wdata = 0 on reads.
REQ-011 rdata_x SHALL hold its last value until the next read completes for that requester; other requester's rdata unaffected.
REQ-012 Requester SHALL hold req/we/addr/wdata stable until gnt and deassert req the cycle after gnt; req still high in IDLE is a new request.
REQ-013 gnt_a and gnt_b SHALL never be 1 simultaneously; same for rvalid_a and rvalid_b.
REQ-014 Address/data SHALL pass unmodified; no forwarding, no address checks (all 2^AW addresses legal).

Reset
REQ-015 rst = 1 at a rising edge SHALL force state IDLE, pointer favouring A, and all outputs (gnt_*, rvalid_*, rdata_*, rf_we, rf_re, rf_addr, rf_wdata) to 0.
REQ-016 Reset during ISSUE or RWAIT SHALL abort the access: no gnt/rvalid pulse afterwards, no rf strobe in the cycle after reset.
REQ-017 First IDLE sampling SHALL occur on the first edge with rst = 0.

Verification
REQ-018 A write alone: req_a=1, we_a=1, addr_a=3, wdata_a=0x5A -> next cycle gnt_a=1, rf_we=1, rf_addr=3, rf_wdata=0x5A; back to IDLE.
REQ-019 A read after that write, rf model returns stored data: req_a=1, we_a=0, addr_a=3 -> rf_re=1 in ISSUE, rvalid_a=1, rdata_a=0x5A two cycles later; rvalid_b stays 0.
REQ-020 Contention after reset: req_a=req_b=1 held -> grants A, B, A, B alternate; never both gnt in one cycle.
REQ-021 B writes addr 7 = 0xFF while A requests read addr 7 in the same IDLE after B was last granted -> A read served first (returns old value), then B write.
REQ-022 Reset mid-read: rst=1 in RWAIT -> rvalid_a stays 0, all outputs 0 next cycle, next request after rst=0 granted normally with A priority.
REQ-023 Boundaries: addr 0 and addr 7, data 0x00 and 0xFF on both requesters -> passed unmodified to rf_* and back to rdata_*.
